// File: rtl/float_discriminant_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : float_discriminant_result_buffer
// Summary  : In-order FIFO that captures distributor result pulses (which
//            cannot be back-pressured), classifies each result by real-root
//            count and hands it to a valid/ready consumer. Provides a sticky
//            overflow flag and saturating per-class statistics counters.
// Revision : 1.0 - initial release
// ============================================================================
module float_discriminant_result_buffer #(
  parameter int FLEN  = 64,
  parameter int NE    = 11,
  parameter int DEPTH = 8,
  parameter int CW    = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_vld,
  input  logic [FLEN-1:0] in_res,
  input  logic            in_negative,
  input  logic            in_err,
  output logic            out_vld,
  input  logic            out_rdy,
  output logic [FLEN-1:0] out_res,
  output logic [1:0]      out_class,
  output logic            out_err,
  output logic            full,
  output logic            overflow,
  output logic [CW-1:0]   cnt_none,
  output logic [CW-1:0]   cnt_one,
  output logic [CW-1:0]   cnt_two,
  output logic [CW-1:0]   cnt_err
);

  localparam int              c_AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [c_AW:0]   c_DEPTH_CNT = (c_AW + 1)'(DEPTH);
  localparam logic [1:0]      c_CLS_NONE  = 2'd0;
  localparam logic [1:0]      c_CLS_ONE   = 2'd1;
  localparam logic [1:0]      c_CLS_TWO   = 2'd2;
  localparam logic [1:0]      c_CLS_ERR   = 2'd3;

  // Storage and bookkeeping
  logic [FLEN-1:0] r_mem_res [DEPTH];
  logic [1:0]      r_mem_cls [DEPTH];
  logic [c_AW-1:0] r_wr_ptr;
  logic [c_AW-1:0] r_rd_ptr;
  logic [c_AW:0]   r_count;
  logic            r_overflow;
  logic [CW-1:0]   r_cnt [4];

  logic [1:0]      w_class;
  logic            w_exp_ones;
  logic            w_mag_zero;
  logic            w_full;
  logic            w_empty;
  logic            w_pop;
  logic            w_push;
  logic            w_drop;

  assign w_exp_ones = &in_res[FLEN-2 -: NE];
  assign w_mag_zero = (in_res[FLEN-2:0] == '0);

  // Root-count classification of the incoming result; error dominates zero.
  always_comb begin
    w_class = c_CLS_TWO;
    if (in_err || w_exp_ones) begin
      w_class = c_CLS_ERR;
    end else if (w_mag_zero) begin
      w_class = c_CLS_ONE;
    end else if (in_negative) begin
      w_class = c_CLS_NONE;
    end
  end

  assign w_full  = (r_count == c_DEPTH_CNT);
  assign w_empty = (r_count == '0);
  // Pop depends only on registered occupancy, so a full FIFO can still
  // accept a push in the same cycle as it drains one entry.
  assign w_pop   = !w_empty && out_rdy;
  assign w_push  = in_vld && (!w_full || w_pop);
  assign w_drop  = in_vld && w_full && !w_pop;

  // Entry storage: written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem_res[i] <= '0;
        r_mem_cls[i] <= '0;
      end
    end else if (w_push) begin
      r_mem_res[r_wr_ptr] <= in_res;
      r_mem_cls[r_wr_ptr] <= w_class;
    end
  end

  // Pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (!w_push && w_pop) begin
        r_count <= r_count - 1'b1;
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Per-class saturating statistics; dropped results are never counted.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 4; k++) begin
        r_cnt[k] <= '0;
      end
    end else if (w_push && !(&r_cnt[w_class])) begin
      r_cnt[w_class] <= r_cnt[w_class] + 1'b1;
    end
  end

  assign out_vld   = !w_empty;
  assign out_res   = r_mem_res[r_rd_ptr];
  assign out_class = r_mem_cls[r_rd_ptr];
  assign out_err   = (r_mem_cls[r_rd_ptr] == c_CLS_ERR);
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign cnt_none  = r_cnt[0];
  assign cnt_one   = r_cnt[1];
  assign cnt_two   = r_cnt[2];
  assign cnt_err   = r_cnt[3];

endmodule
`default_nettype wire

// File: tb/tb_float_discriminant_result_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_float_discriminant_result_buffer
// Summary  : Scoreboard bench for float_discriminant_result_buffer. Expected
//            entries are queued when a push is driven and compared when the
//            DUT hands the head entry to the consumer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_float_discriminant_result_buffer;

  localparam int c_DEPTH = 8;
  localparam int c_CW    = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            in_vld = 1'b0;
  logic [63:0]     in_res = '0;
  logic            in_negative = 1'b0;
  logic            in_err = 1'b0;
  logic            out_vld;
  logic            out_rdy = 1'b0;
  logic [63:0]     out_res;
  logic [1:0]      out_class;
  logic            out_err;
  logic            full;
  logic            overflow;
  logic [c_CW-1:0] cnt_none, cnt_one, cnt_two, cnt_err;

  float_discriminant_result_buffer #(
    .FLEN(64), .NE(11), .DEPTH(c_DEPTH), .CW(c_CW)
  ) dut (
    .clk(clk), .rst(rst),
    .in_vld(in_vld), .in_res(in_res), .in_negative(in_negative), .in_err(in_err),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_res(out_res),
    .out_class(out_class), .out_err(out_err),
    .full(full), .overflow(overflow),
    .cnt_none(cnt_none), .cnt_one(cnt_one), .cnt_two(cnt_two), .cnt_err(cnt_err)
  );

  always #5 clk = ~clk;

  // Reference state
  logic [65:0]     sb [$];
  logic [c_CW-1:0] m_cnt [4];
  logic            m_ovf;
  int              n_cmp = 0;
  int              n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [1:0] ref_class(input logic [63:0] d, input logic neg, input logic err);
    logic [10:0] e;
    logic [51:0] m;
    e = d[62:52];
    m = d[51:0];
    if (err || e == 11'h7FF) return 2'd3;
    if (e == 11'h000 && m == 52'h0) return 2'd1;
    if (neg) return 2'd0;
    return 2'd2;
  endfunction

  task automatic clear_model();
    sb.delete();
    for (int k = 0; k < 4; k++) m_cnt[k] = '0;
    m_ovf = 1'b0;
  endtask

  // One clock cycle: drive inputs, check visible state, update the model.
  task automatic step(input logic v, input logic [63:0] d, input logic neg,
                      input logic err, input logic rdy);
    int          size_before;
    logic        pop;
    logic [65:0] e;
    logic [1:0]  c;
    @(negedge clk);
    in_vld = v; in_res = d; in_negative = neg; in_err = err; out_rdy = rdy;
    size_before = sb.size();
    check("out_vld", {63'd0, out_vld}, {63'd0, size_before != 0});
    check("full", {63'd0, full}, {63'd0, size_before == c_DEPTH});
    check("overflow", {63'd0, overflow}, {63'd0, m_ovf});
    check("cnt_none", {48'd0, cnt_none}, {48'd0, m_cnt[0]});
    check("cnt_one", {48'd0, cnt_one}, {48'd0, m_cnt[1]});
    check("cnt_two", {48'd0, cnt_two}, {48'd0, m_cnt[2]});
    check("cnt_err", {48'd0, cnt_err}, {48'd0, m_cnt[3]});
    pop = rdy && (size_before != 0);
    if (pop) begin
      e = sb.pop_front();
      check("out_res", out_res, e[63:0]);
      check("out_class", {62'd0, out_class}, {62'd0, e[65:64]});
      check("out_err", {63'd0, out_err}, {63'd0, e[65:64] == 2'd3});
    end
    if (v) begin
      if (size_before < c_DEPTH || pop) begin
        c = ref_class(d, neg, err);
        sb.push_back({c, d});
        if (m_cnt[c] != 16'hFFFF) m_cnt[c] = m_cnt[c] + 1'b1;
      end else begin
        m_ovf = 1'b1;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) step(1'b0, 64'h0, 1'b0, 1'b0, rdy);
  endtask

  // Reset with in_vld raised to show that it is ignored.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; in_vld = 1'b1; in_res = 64'h4010_0000_0000_0000;
    in_negative = 1'b0; in_err = 1'b0; out_rdy = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0; in_vld = 1'b0;
    clear_model();
  endtask

  initial begin
    clear_model();
    repeat (3) @(posedge clk);
    do_reset();
    check("rst_out_res", out_res, 64'h0);
    check("rst_out_class", {62'd0, out_class}, 64'h0);
    check("rst_out_vld", {63'd0, out_vld}, 64'h0);
    idle(2, 1'b1);

    // Single positive value: two real roots, visible for exactly one cycle.
    step(1'b1, 64'h4010_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // +0, -0, then -4.0
    step(1'b1, 64'h0000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 64'hC010_0000_0000_0000, 1'b1, 1'b0, 1'b1);
    idle(4, 1'b1);

    // Error flag, then infinity without the error flag
    step(1'b1, 64'h7FF1_2345_6789_ABCD, 1'b0, 1'b1, 1'b1);
    step(1'b1, 64'h7FF0_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);
    check("cnt_err_total", {48'd0, cnt_err}, 64'd2);

    // Overfill with consumer stalled, then drain.
    for (int i = 0; i < 9; i++)
      step(1'b1, 64'h3FF0_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    check("ovf_after_fill", {63'd0, overflow}, 64'd1);
    idle(10, 1'b1);

    // Full FIFO with sustained push+pop across pointer wrap
    do_reset();
    for (int i = 0; i < c_DEPTH; i++)
      step(1'b1, 64'hBFF0_0000_0000_0000 + 64'(i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      step(1'b1, 64'h4000_0000_0000_0000 + 64'(i << 4), 1'b0, 1'b0, 1'b1);
    check("ovf_stream", {63'd0, overflow}, 64'd0);
    idle(10, 1'b1);

    // Reset mid-operation discards entries
    for (int i = 0; i < 3; i++)
      step(1'b1, 64'h4020_0000_0000_0000 + 64'(i), 1'b0, 1'b0, 1'b0);
    do_reset();
    check("mid_rst_vld", {63'd0, out_vld}, 64'd0);
    check("mid_rst_cnt_two", {48'd0, cnt_two}, 64'd0);
    step(1'b1, 64'h4030_0000_0000_0000, 1'b0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // Random traffic with occasional special encodings
    for (int i = 0; i < 200; i++) begin
      logic [63:0] d;
      d = {$urandom, $urandom};
      case ($urandom_range(0, 5))
        0: d[62:52] = 11'h7FF;
        1: d[62:0]  = '0;
        default: ;
      endcase
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 2) != 0));
    end
    idle(12, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/float_discriminant_result_buffer.md
# float_discriminant_result_buffer

Downstream stage of the floating-point discriminant distributor. Captures every result pulse the distributor emits, which carries no backpressure, into an in-order FIFO. Classifies each result by real-root count and presents it to the consumer through a valid/ready handshake. Keeps sticky overflow and per-class statistics counters for the bench and debug.

## Interface

Parameters:
- FLEN, 64, float width (IEEE-754 double).
- NE, 11, exponent width.
- DEPTH, 8, FIFO entries; power of two, ≥ 2.
- CW, 16, statistics counter width.

Ports:
- clk  input  1  clock; all logic on posedge.
- rst  input  1  reset; synchronous, active-high.
- in_vld  input  1  result valid pulse from the distributor.
- in_res  input  FLEN  discriminant value.
- in_negative  input  1  result negative flag.
- in_err  input  1  result error flag.
- out_vld  output  1  head entry valid.
- out_rdy  input  1  consumer ready.
- out_res  output  FLEN  head discriminant value.
- out_class  output  2  root class: 0 NONE, 1 ONE, 2 TWO, 3 ERR.
- out_err  output  1  head error flag; equals (out_class == 3).
- full  output  1  FIFO holds DEPTH entries.
- overflow  output  1  sticky; set when a push was dropped.
- cnt_none, cnt_one, cnt_two, cnt_err  output  CW each  saturating counts of accepted results per class.

## Operation

- Classification is computed combinationally on the input side and stored with the entry:
  - ERR if in_err = 1, or if exponent in_res[FLEN-2 -: NE] is all ones (inf/NaN).
  - Otherwise ONE if in_res[FLEN-2:0] == 0. Covers +0.0 and −0.0.
  - Otherwise NONE if in_negative = 1.
  - Otherwise TWO.
- Push rules:
  - Push accepted when in_vld and (not full, or a pop in the same cycle).
  - Push dropped when in_vld, full and no pop. A dropped push sets overflow = 1, which stays set until rst. Dropped results are not counted.
- Pop occurs when out_vld and out_rdy.
- Storage is a circular buffer with read/write pointers of log2(DEPTH) bits that wrap naturally, plus an occupancy count of log2(DEPTH)+1 bits.
  - full = (count == DEPTH).
  - out_vld = (count != 0).
- Counters:
  - The counter for the stored class increments on each accepted push.
  - Counters saturate at all-ones; no wrap.
- Ordering is strictly first-in first-out; no reordering and no bypass.
- out_res, out_class and out_err are driven from the head entry. They are don't-care when out_vld = 0, but must not be X after reset; storage is reset to 0.

## Timing

- Reset values: out_vld 0, full 0, overflow 0, all counters 0, pointers 0, count 0, out_* 0.
- Latency: a push at posedge N gives out_vld = 1 with that entry visible after posedge N, i.e. in cycle N+1. Zero-cycle passthrough is not allowed.
- Throughput: one push and one pop per cycle sustained. Simultaneous push and pop leaves count unchanged.
- Empty with simultaneous in_vld and out_rdy: no pop, because out_vld = 0. The push is accepted.
- Full with simultaneous push and pop: both occur. count stays DEPTH, full stays 1, overflow is unchanged.
- out_vld must not depend combinationally on out_rdy. Head data must stay stable while out_vld = 1 and out_rdy = 0.
- rst asserted mid-operation discards all entries at that posedge and clears overflow and counters. in_vld during rst is ignored.
- Pointer wrap: after DEPTH pushes and pops, the pointers return to 0 with no loss or duplication.

## Test plan

- Push a single 0x4010_0000_0000_0000 (4.0), in_negative 0, in_err 0, with out_rdy 1 → out_vld for exactly one cycle in the next cycle, out_class 2, cnt_two 1.
- Push 0x0000_0000_0000_0000, then 0x8000_0000_0000_0000, then 0xC010_0000_0000_0000 (−4.0, in_negative 1) → classes 1, 1, 0 in order; cnt_one 2, cnt_none 1.
- Push 0x7FF1_2345_6789_ABCD with in_err 1, then 0x7FF0_0000_0000_0000 with in_err 0 → both class 3, out_err 1, cnt_err 2.
- With out_rdy 0, push 9 distinct values back-to-back → full 1 after the 8th push; the 9th is dropped; overflow 1; counters total 8. Raising out_rdy then drains the first 8 in order, and full falls after the first pop.
- With the FIFO full, push with out_rdy 1 every cycle for 20 cycles → no drops, overflow stays 0, output order matches input order across pointer wrap.
- Push 3 entries, then assert rst for 1 cycle → out_vld 0, counters 0, overflow 0. A new push afterwards is output first and alone.
